// File: rtl/mesi_pkg.sv
// mesi_pkg: MESI encodings, array line layout, bus opcodes and snoop FSM states.
package mesi_pkg;
  typedef enum logic [2:0] {
    INVALID   = 3'b000,
    SHARED    = 3'b001,
    EXCLUSIVE = 3'b010,
    MODIFIED  = 3'b011
  } mesi_t;
  typedef enum logic [1:0] {
    BUS_RD  = 2'd0,
    BUS_RDX = 2'd1,
    BUS_INV = 2'd2
  } bus_op_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, EVAL, WRITE, DONE} fsm_t;
  localparam int TAG_HI  = 13;
  localparam int TAG_LO  = 11;
  localparam int ST_HI   = 10;
  localparam int ST_LO   = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;
endpackage

// File: rtl/mesi_snoop_next.sv
// mesi_snoop_next: snooped MESI downgrade for one bus op (E/M under BUS_INV behave like BUS_RDX).
module mesi_snoop_next
  import mesi_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] cur,
  input  logic       hit,
  output logic [2:0] nxt,
  output logic       shared,
  output logic       supply
);
  assign nxt    = !hit ? cur : op == BUS_RD ? SHARED : (op == BUS_RDX || op == BUS_INV) ? INVALID : cur;
  assign shared = hit;
  assign supply = hit && cur == MODIFIED;
endmodule

// File: rtl/snoop_responder.sv
// snoop_responder: snoop-side MESI responder for one 4-line direct-mapped cache.
// SNOOP_STATS_EN enables the saturating hit/invalidation counters.
module snoop_responder
  import mesi_pkg::*;
#(
  parameter logic [1:0] CPU_ID = 2'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic [1:0]  bus_src,
  input  logic [1:0]  bus_op,
  input  logic [2:0]  bus_addr,
  output logic        snp_ack,
  output logic        snp_shared,
  output logic        snp_supply,
  output logic [7:0]  snp_data,
  input  logic        arr_busy,
  output logic        arr_rd,
  output logic        arr_we,
  output logic [1:0]  arr_addr,
  output logic [13:0] arr_wdata,
  input  logic [13:0] arr_rdata,
  output logic [7:0]  snp_hit_cnt,
  output logic [7:0]  snp_inv_cnt
);
  fsm_t        state, next;
  logic [1:0]  op_q;
  logic [2:0]  addr_q;
  logic [13:0] line_q;
  logic [2:0]  cur_st, nxt_st;
  logic        hit, sh, sp;
  assign cur_st = arr_rdata[ST_HI:ST_LO];
  assign hit    = arr_rdata[TAG_HI:TAG_LO] == addr_q && cur_st != INVALID;
  mesi_snoop_next u_next (
    .op    (op_q),
    .cur   (cur_st),
    .hit   (hit),
    .nxt   (nxt_st),
    .shared(sh),
    .supply(sp)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= 2'd0;
      addr_q     <= 3'd0;
      line_q     <= 14'd0;
      snp_shared <= 1'b0;
      snp_supply <= 1'b0;
      snp_data   <= 8'd0;
    end else begin
      state <= next;
      if (state == IDLE && bus_valid) begin
        op_q   <= bus_op;
        addr_q <= bus_addr;
      end
      if (state == EVAL) begin
        snp_shared <= sh;
        snp_supply <= sp;
        snp_data   <= sp ? arr_rdata[DATA_HI:DATA_LO] : 8'd0;
        line_q     <= {arr_rdata[TAG_HI:TAG_LO], nxt_st, arr_rdata[DATA_HI:DATA_LO]};
      end
      if (state == DONE) begin
        snp_shared <= 1'b0;
        snp_supply <= 1'b0;
        snp_data   <= 8'd0;
      end
    end
  end
  always_comb begin
    next   = state;
    arr_rd = 1'b0;
    arr_we = 1'b0;
    unique case (state)
      IDLE:    next = !bus_valid ? IDLE : bus_src == CPU_ID ? DONE : LOOKUP;
      LOOKUP: begin
        arr_rd = !arr_busy;
        next   = arr_busy ? LOOKUP : EVAL;
      end
      EVAL:    next = nxt_st != cur_st ? WRITE : DONE;
      WRITE: begin
        arr_we = !arr_busy;
        next   = arr_busy ? WRITE : DONE;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign snp_ack   = state == DONE;
  assign arr_addr  = (arr_rd || arr_we) ? addr_q[1:0] : 2'd0;
  assign arr_wdata = arr_we ? line_q : 14'd0;
`ifdef SNOOP_STATS_EN
  logic [7:0] hit_cnt, inv_cnt;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_cnt <= 8'd0;
      inv_cnt <= 8'd0;
    end else begin
      if (state == DONE && snp_shared && hit_cnt != 8'hff) hit_cnt <= hit_cnt + 8'd1;
      if (arr_we && line_q[ST_HI:ST_LO] == INVALID && inv_cnt != 8'hff) inv_cnt <= inv_cnt + 8'd1;
    end
  end
  assign snp_hit_cnt = hit_cnt;
  assign snp_inv_cnt = inv_cnt;
`else
  assign snp_hit_cnt = 8'd0;
  assign snp_inv_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed and randomized snoop traffic against an array emulation and a reference line model.
module tb_snoop_responder;
  logic        clock = 0, reset_n = 0, bus_valid = 0, arr_busy = 0;
  logic [1:0]  bus_src = 0, bus_op = 0;
  logic [2:0]  bus_addr = 0;
  logic        snp_ack, snp_shared, snp_supply, arr_rd, arr_we;
  logic [7:0]  snp_data, snp_hit_cnt, snp_inv_cnt;
  logic [1:0]  arr_addr;
  logic [13:0] arr_wdata, arr_rdata = 0;
  int n_cmp = 0, n_bad = 0;
  logic [13:0] mem[4];
  logic [13:0] ref_mem[4];
  logic        load_en = 0;
  logic [1:0]  load_idx = 0;
  logic [13:0] load_val = 0;
  logic        ack_ok = 0, exp_sh = 0, exp_sp = 0, exp_we = 0;
  logic [7:0]  exp_data = 0;
  logic [1:0]  exp_idx = 0;
  logic [13:0] exp_line = 0;
  int          we_seen = 0, ack_seen = 0, rd_seen = 0, m_hit = 0, m_inv = 0, lat = 0;
  logic        last_sh = 0, last_sp = 0;
  logic [7:0]  last_data = 0;

  snoop_responder dut (
    .clock(clock), .reset_n(reset_n), .bus_valid(bus_valid), .bus_src(bus_src),
    .bus_op(bus_op), .bus_addr(bus_addr), .snp_ack(snp_ack), .snp_shared(snp_shared),
    .snp_supply(snp_supply), .snp_data(snp_data), .arr_busy(arr_busy), .arr_rd(arr_rd),
    .arr_we(arr_we), .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .snp_hit_cnt(snp_hit_cnt), .snp_inv_cnt(snp_inv_cnt)
  );

  always #5 clock = ~clock;

  // Array emulation: registered read data, plus a side port for preloading lines.
  always @(posedge clock) begin
    if (arr_rd) arr_rdata <= mem[arr_addr];
    if (arr_we) mem[arr_addr] <= arr_wdata;
    if (load_en) mem[load_idx] <= load_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("rd_we_exclusive", {31'd0, arr_rd & arr_we}, 0);
    if (!snp_supply) chk("data_gated", snp_data, 0);
    if (arr_rd) rd_seen++;
    if (arr_we) begin
      we_seen++;
      chk("we_allowed", exp_we, 1);
      chk("we_addr", arr_addr, exp_idx);
      chk("we_line", arr_wdata, exp_line);
    end
    if (snp_ack) begin
      ack_seen++;
      last_sh = snp_shared;
      last_sp = snp_supply;
      last_data = snp_data;
      chk("ack_allowed", ack_ok, 1);
      chk("shared", snp_shared, exp_sh);
      chk("supply", snp_supply, exp_sp);
      chk("data", snp_data, exp_data);
    end
    if (!reset_n) begin
      chk("rst_outputs", {snp_ack, snp_shared, snp_supply, arr_rd, arr_we, snp_data}, 0);
      chk("rst_counters", {snp_hit_cnt, snp_inv_cnt}, 0);
    end
  end

  task automatic preload(input logic [1:0] idx, input logic [13:0] val);
    load_en = 1; load_idx = idx; load_val = val;
    ref_mem[idx] = val;
    @(posedge clock); #1 load_en = 0;
  endtask

  task automatic check_counters();
`ifdef SNOOP_STATS_EN
    chk("hit_cnt", snp_hit_cnt, m_hit);
    chk("inv_cnt", snp_inv_cnt, m_inv);
`else
    chk("hit_cnt_tied", snp_hit_cnt, 0);
    chk("inv_cnt_tied", snp_inv_cnt, 0);
`endif
  endtask

  // One snoop transaction; expectations derived from the reference line model.
  task automatic txn(input logic [1:0] src, input logic [1:0] op, input logic [2:0] addr,
                     input int busy_n, input bit rnd);
    logic [13:0] l;
    logic [2:0] st, ns;
    logic self, hit;
    int base, nb;
    l = ref_mem[addr[1:0]];
    st = l[10:8];
    self = src == 2'd0;
    hit = !self && l[13:11] == addr && st != 3'd0;
    ns = !hit ? st : (op == 2'd0 ? 3'd1 : 3'd0);
    exp_sh = hit;
    exp_sp = hit && st == 3'd3;
    exp_data = exp_sp ? l[7:0] : 8'd0;
    exp_we = ns != st;
    exp_idx = addr[1:0];
    exp_line = {l[13:11], ns, l[7:0]};
    ack_ok = 1; we_seen = 0; ack_seen = 0; rd_seen = 0;
    base = self ? 1 : exp_we ? 4 : 3;
    bus_valid = 1; bus_src = src; bus_op = op; bus_addr = addr;
    @(posedge clock);
    lat = 1; nb = 0;
    forever begin
      #1 arr_busy = (!self && lat <= busy_n) || (rnd && $urandom_range(0, 3) == 0);
      nb += int'(arr_busy);
      @(negedge clock);
      if (snp_ack) break;
      if (lat >= 40) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_timeout: no ack after %0d cycles, required within %0d", lat, base + nb);
        break;
      end
      @(posedge clock);
      lat++;
    end
    @(posedge clock);
    #1 bus_valid = 0; arr_busy = 0;
    ack_ok = 0;
    if (rnd) begin
      chk("lat_min", {31'd0, lat >= base}, 1);
      chk("lat_max", {31'd0, lat <= base + nb}, 1);
    end else chk("latency", lat, base + busy_n);
    chk("ack_count", ack_seen, 1);
    chk("rd_count", rd_seen, self ? 0 : 1);
    chk("we_count", we_seen, {31'd0, exp_we});
    if (exp_we) ref_mem[addr[1:0]] = exp_line;
    chk("array_line", mem[addr[1:0]], ref_mem[addr[1:0]]);
    if (hit && m_hit < 255) m_hit++;
    if (exp_we && ns == 3'd0 && m_inv < 255) m_inv++;
    check_counters();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] a, tg;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) preload(i[1:0], {3'd4, 3'd0, 8'd0});
    reset_n = 1;
    check_counters();
    // Modified line supplies data and drops to Shared
    preload(2'd2, {3'b010, 3'b011, 8'd30});
    txn(2'd1, 2'd0, 3'b010, 0, 0);
    chk("t1_lat", lat, 4);
    chk("t1_shared", last_sh, 1);
    chk("t1_supply", last_sp, 1);
    chk("t1_data", last_data, 30);
    chk("t1_line", mem[2], 14'b010_001_00011110);
    // Shared line invalidated by a write miss
    preload(2'd1, {3'b001, 3'b001, 8'd8});
    txn(2'd2, 2'd1, 3'b001, 0, 0);
    chk("t2_shared", last_sh, 1);
    chk("t2_supply", last_sp, 0);
    chk("t2_data", last_data, 0);
    chk("t2_line", mem[1], 14'b001_000_00001000);
`ifdef SNOOP_STATS_EN
    chk("t2_inv_cnt", snp_inv_cnt, 1);
`endif
    // Invalid line is a miss
    preload(2'd0, {3'b000, 3'b000, 8'd10});
    txn(2'd1, 2'd0, 3'b100, 0, 0);
    chk("t3_lat", lat, 3);
    chk("t3_shared", last_sh, 0);
    // Self-originated request
    txn(2'd0, 2'd0, 3'b010, 0, 0);
    chk("t4_lat", lat, 1);
    chk("t4_shared", last_sh, 0);
    // Array busy for two LOOKUP cycles
    preload(2'd2, {3'b010, 3'b011, 8'd30});
    txn(2'd1, 2'd0, 3'b010, 2, 0);
    chk("t5_lat", lat, 6);
    chk("t5_data", last_data, 30);
    chk("t5_line", mem[2], 14'b010_001_00011110);
    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        tg = $urandom_range(0, 2) != 0 ? a : 3'($urandom_range(0, 7));
        preload(a[1:0], {tg, 3'($urandom_range(0, 3)), 8'($urandom_range(0, 255))});
      end
      txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), a, 0, 1);
    end
    // Reset during EVAL drops the pending write
    preload(2'd2, {3'b010, 3'b011, 8'd30});
    ack_ok = 0; exp_we = 0;
    bus_valid = 1; bus_src = 2'd1; bus_op = 2'd0; bus_addr = 3'b010;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 0; bus_valid = 0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1;
    m_hit = 0; m_inv = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("t6_line", mem[2], 14'b010_011_00011110);
    chk("t6_outputs", {snp_ack, snp_shared, snp_supply, snp_data}, 0);
    check_counters();
    txn(2'd1, 2'd0, 3'b010, 0, 0);
    chk("t6_recover_lat", lat, 4);
    chk("t6_recover_data", last_data, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snoop_responder.md
# snoop_responder

Snoop-side responder for one MESI cache in the three-cache snooping system. Accepts bus transactions issued by other processors' controllers, looks up the addressed line in its local 4-line direct-mapped cache array, answers with shared/supply/data, and writes the downgraded MESI state back into the array. It is the responder end of the coherence bus that the processor-side cache controllers initiate on.

## Interface
- CPU_ID, 2'd0, processor number of the owning cache; transactions with bus_src == CPU_ID are ignored.
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- bus_valid  in  1  snoop request present; held until snp_ack
- bus_src  in  2  originating processor
- bus_op  in  2  BUS_RD (read miss), BUS_RDX (write miss), BUS_INV (upgrade/invalidate)
- bus_addr  in  3  block address (100..138 → 000..111)
- snp_ack  out  1  one-cycle completion pulse; response fields valid in this cycle
- snp_shared  out  1  line was held in S/E/M
- snp_supply  out  1  line was M; snp_data carries it and memory must write back
- snp_data  out  8  supplied data, 0 when snp_supply low
- arr_busy  in  1  local controller owns the array this cycle
- arr_rd  out  1  array read strobe
- arr_we  out  1  array write strobe
- arr_addr  out  2  line index = bus_addr[1:0]
- arr_wdata  out  14  {tag[13:11], state[10:8], data[7:0]}
- arr_rdata  in  14  line read, registered, valid the cycle after arr_rd
- snp_hit_cnt  out  8  hit counter (see Configuration)
- snp_inv_cnt  out  8  invalidation counter (see Configuration)

## Operation
- Hit = arr_rdata tag == bus_addr and state != INVALID.
- Transitions on hit: BUS_RD: M→S (supply), E→S, S→S. BUS_RDX: M→I (supply), E/S→I. BUS_INV: S→I; E/M treated as BUS_RDX. Miss: no change, all response bits 0.
- Tag and data fields written back unchanged; only state is modified.
- FSM states: IDLE, LOOKUP, EVAL, WRITE, DONE.
  - IDLE: on bus_valid, latch src/op/addr; src == CPU_ID → DONE (all response bits 0), else → LOOKUP.
  - LOOKUP: arr_busy high → stay, strobes low; else arr_rd=1, arr_addr=index → EVAL.
  - EVAL: evaluate arr_rdata; register snp_shared/snp_supply/snp_data; state change → WRITE, else → DONE.
  - WRITE: arr_busy high → stay with arr_we low; else arr_we=1 with new line → DONE.
  - DONE: snp_ack=1 → IDLE. bus_valid sampled only in IDLE, so a held request is not re-accepted after ack.
- Response fields hold from EVAL until the cycle after DONE, then clear to 0.

## Timing
- Request accepted at edge k (IDLE). No contention: write path ack at k+4, no-write path ack at k+3, self-originated ack at k+1.
- Each arr_busy cycle in LOOKUP or WRITE adds one cycle.
- Reset values: every output 0, FSM IDLE, counters 0.
- reset_n low mid-operation: next edge returns IDLE, strobes and response cleared, pending array write dropped, no ack.
- arr_rd and arr_we never asserted in the same cycle.

## Configuration
- SNOOP_STATS_EN defined: snp_hit_cnt increments at DONE on every hit; snp_inv_cnt increments on every transition to I; both saturate at 255, reset to 0.
- Undefined: counter logic absent, both ports tied to 0.

## Structure
- mesi_pkg: state encodings (INVALID 3'b000, SHARED 3'b001, EXCLUSIVE 3'b010, MODIFIED 3'b011), field positions (TAG 13:11, STATE 10:8, DATA 7:0), bus opcodes, FSM state type.
- One sub-module: mesi_snoop_next (combinational: op, state, hit → next state, shared, supply).

## Test plan
- Array line 2 = {010, M, 30}; BUS_RD addr 010 src 1 → ack at k+4, shared=1, supply=1, data=30; line written {010, S, 30}.
- Line 1 = {001, S, 8}; BUS_RDX addr 001 src 2 → shared=1, supply=0, data=0; line becomes {001, I, 8}; snp_inv_cnt=1 with SNOOP_STATS_EN.
- Line 0 = {000, I, 10}; BUS_RD addr 100 → miss, ack at k+3, no arr_we.
- bus_src == CPU_ID → ack at k+1, no arr_rd, response 0.
- arr_busy high for 2 cycles in LOOKUP, Test 1 stimulus → ack at k+6, same result.
- reset_n low during EVAL of Test 1 → no arr_we, no ack, outputs 0, line remains M.
